alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Stage3 result collector and output register. Sits directly downstream of the
//  ALU_TOP execution units (adder, logic unit, barrel_shifter) and upstream of
//  the memory stage.
//  - Selects one unit's result and derives SLT and zero.
//  - Applies the overflow-trap rule.
//  - Hands the packet to the memory stage over a valid/ready link.
//  - A 2-entry skid buffer decouples memory-stage stalls from Stage3.
// PARAMETERS
//  DATA_W  32  datapath width (adder/logic/shifter result width)
//  REG_AW  5   destination register index width
// PORTS
//  clk            in   1       single clock, rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  in_valid       in   1       Stage3 packet valid
//  in_ready       out  1       stage can accept a packet this cycle
//  flush          in   1       synchronous pipeline flush (branch/exception)
//  result_sel     in   2       00=ADD/SUB, 01=LOGIC, 10=SHIFT, 11=SLT
//  add_res        in   DATA_W  adder/subtractor result
//  add_ovf        in   1       signed overflow from adder
//  ovf_trap_en    in   1       op is trapping (ADD/SUB/ADDI, not the U forms)
//  logic_res      in   DATA_W  AND/OR/XOR/NOR/LUI result
//  shift_res      in   DATA_W  barrel_shifter out_data
//  dest_reg       in   REG_AW  writeback register index
//  reg_write      in   1       packet writes the register file
//  out_valid      out  1       packet valid to memory stage
//  out_ready      in   1       memory stage accepts the packet
//  out_result     out  DATA_W  selected result
//  out_dest       out  REG_AW  destination index
//  out_reg_write  out  1       write enable (gated by overflow trap)
//  out_zero       out  1       out_result == 0
//  out_ovf_exc    out  1       overflow exception request
// BEHAVIOUR
//  - Reset (rst_n=0, async): both entries empty; out_valid=0, out_result=0,
//    out_dest=0, out_reg_write=0, out_zero=0, out_ovf_exc=0. in_ready=1 from
//    the first edge after rst_n deasserts. Reset mid-transfer discards all data.
//  - Handshake:
//    - Accept when in_valid & in_ready.
//    - Deliver when out_valid & out_ready.
//    - out_* stay stable while out_valid=1 and out_ready=0.
//  - Latency: an accepted packet appears on out_* the next cycle if the stage
//    was empty. The result path is always fully registered; no comb in->out path.
//  - Occupancy states:
//    - EMPTY:
//      - push -> ONE
//    - ONE:
//      - push & pop -> ONE (new packet becomes head)
//      - push only -> TWO
//      - pop only -> EMPTY
//    - TWO:
//      - pop -> ONE
//      - no push is possible in TWO
//  - in_ready is a flop: 1 unless state is TWO, or state is ONE with
//    push & ~pop in the current cycle. This gives the registered-ready skid
//    behaviour.
//  - Result select and derived fields:
//    - Result by sel: 00 add_res, 01 logic_res, 10 shift_res.
//    - sel 11 (SLT): result = {(DATA_W-1)'b0, add_res[DATA_W-1]^add_ovf}.
//    - out_zero is computed on the selected result at capture, not at output.
//  - Overflow trap, when sel==00 & add_ovf & ovf_trap_en:
//    - out_reg_write=0 and out_ovf_exc=1; the packet is still delivered.
//    - Otherwise out_ovf_exc=0 and out_reg_write=reg_write.
//    - add_ovf is ignored for sel 01/10. For sel 11 it affects only the SLT bit.
//  - Flush (synchronous):
//    - Next cycle: both entries cleared, out_valid=0, in_ready=1.
//    - A packet offered in the flush cycle is dropped.
//    - A pop in the flush cycle completes normally.
//  - Wrap/width: all selects are DATA_W wide; no truncation or extension except SLT.
// STRUCTURE
//  - Shared package alu_stage_pkg:
//    - RES_ADD/RES_LOGIC/RES_SHIFT/RES_SLT localparams (2-bit).
//    - Packet field widths (DATA_W+REG_AW+3).
//  - Sub-module skid_buffer2:
//    - Generic 2-entry valid/ready buffer, WIDTH parameter, rst_n async, flush.
//    - Instantiated once on the packed {result,dest,reg_write,zero,ovf_exc}.
//  - Top level: result mux, SLT, zero and trap logic feeding skid_buffer2.
// TESTING
//  1 Reset then single push:
//    - sel=10, shift_res=32'h8000_0000, dest=5, reg_write=1, out_ready=1.
//    - Next cycle: out_valid=1, out_result=32'h8000_0000, out_zero=0, out_dest=5.
//  2 SLT:
//    - sel=11, add_res=32'h7FFF_FFFF, add_ovf=1.
//    - Expect out_result=1.
//    - Then add_res=32'h8000_0000, add_ovf=1: out_result=0, out_zero=1.
//  3 Overflow trap:
//    - sel=00, add_ovf=1, ovf_trap_en=1, reg_write=1.
//    - Expect out_reg_write=0, out_ovf_exc=1.
//    - Same with ovf_trap_en=0: out_reg_write=1, out_ovf_exc=0.
//  4 Backpressure:
//    - out_ready=0; push A, B back-to-back.
//    - After B accepted: in_ready=0; out_* hold A.
//    - Raise out_ready: A then B delivered in order, in_ready=1 after A pops.
//  5 Flush and reset:
//    - Fill to TWO, pulse flush with in_valid=1 (packet C).
//    - Next cycle: out_valid=0, in_ready=1, C never appears.
//    - Repeat with async rst_n low mid-cycle: outputs go 0 immediately.

Source files
------------

// File: rtl/alu_stage_pkg.sv
// Shared definitions for the Stage3 result collector: result-select codes,
// occupancy encoding of the output skid buffer and packet width helper.
package alu_stage_pkg;

   localparam logic [1:0] RES_ADD   = 2'b00;
   localparam logic [1:0] RES_LOGIC = 2'b01;
   localparam logic [1:0] RES_SHIFT = 2'b10;
   localparam logic [1:0] RES_SLT   = 2'b11;

   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;

   // Trailing flag bits in a packet: reg_write, zero, ovf_exc.
   localparam int PKT_FLAG_W = 3;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_e;

   function automatic int pkt_width(input int data_w, input int reg_aw);
      return data_w + reg_aw + PKT_FLAG_W;
   endfunction

endpackage

// File: rtl/alu_result_stage_skid.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready, async
// active-low reset and synchronous flush. Head entry drives out_data directly.
module skid_buffer2
   import alu_stage_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       dbg_state
);

   // Handshake: a beat moves on an edge where valid & ready are both high;
   // once valid is raised the data is held until that edge.
   occ_state_e       state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             in_ready_q, in_ready_d;
   logic             push, pop;

   assign out_valid = (state_q != OCC_EMPTY);
   assign out_data  = head_q;
   assign in_ready  = in_ready_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      push       = in_valid & in_ready_q & ~flush;
      pop        = out_valid & out_ready;
      if (flush) begin
         state_d = OCC_EMPTY;
         head_d  = '0;
         tail_d  = '0;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (push) begin
                  state_d = OCC_ONE;
                  head_d  = in_data;
               end
            end
            OCC_ONE: begin
               if (push && pop) begin
                  head_d = in_data;
               end else if (push) begin
                  state_d = OCC_TWO;
                  tail_d  = in_data;
               end else if (pop) begin
                  state_d = OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  state_d = OCC_ONE;
                  head_d  = tail_q;
               end
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
      in_ready_d = (state_d != OCC_TWO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= OCC_EMPTY;
         head_q     <= '0;
         tail_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Stage3 result collector: picks the execution-unit result, derives SLT, zero
// and the overflow trap, and registers the packet towards the memory stage.
module alu_result_stage
   import alu_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [1:0]        result_sel,
   input  logic [DATA_W-1:0] add_res,
   input  logic              add_ovf,
   input  logic              ovf_trap_en,
   input  logic [DATA_W-1:0] logic_res,
   input  logic [DATA_W-1:0] shift_res,
   input  logic [REG_AW-1:0] dest_reg,
   input  logic              reg_write,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_AW-1:0] out_dest,
   output logic              out_reg_write,
   output logic              out_zero,
   output logic              out_ovf_exc
);

   localparam int PKT_W = pkt_width(DATA_W, REG_AW);

   logic [DATA_W-1:0] sel_result;
   logic              slt_bit;
   logic              trap;
   logic              sel_zero;
   logic [PKT_W-1:0]  pkt_in;
   logic [PKT_W-1:0]  pkt_out;
   logic [1:0]        skid_state_unused;

   // Signed less-than: sign of the difference corrected by overflow.
   assign slt_bit = add_res[DATA_W-1] ^ add_ovf;

   always_comb begin
      sel_result = '0;
      case (result_sel)
         RES_ADD:   sel_result = add_res;
         RES_LOGIC: sel_result = logic_res;
         RES_SHIFT: sel_result = shift_res;
         RES_SLT:   sel_result = {{(DATA_W-1){1'b0}}, slt_bit};
         default:   sel_result = '0;
      endcase
   end

   assign trap     = (result_sel == RES_ADD) & add_ovf & ovf_trap_en;
   assign sel_zero = (sel_result == '0);
   assign pkt_in   = {sel_result, dest_reg, reg_write & ~trap, sel_zero, trap};

   skid_buffer2 #(
      .WIDTH(PKT_W)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (pkt_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (pkt_out),
      .dbg_state(skid_state_unused)
   );

   assign {out_result, out_dest, out_reg_write, out_zero, out_ovf_exc} = pkt_out;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: expected packets are queued at issue time
// and a negedge monitor pops and compares each delivered packet.
module tb_alu_result_stage;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int PKT_W  = DATA_W + REG_AW + 3;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              flush;
   logic [1:0]        result_sel;
   logic [DATA_W-1:0] add_res;
   logic              add_ovf;
   logic              ovf_trap_en;
   logic [DATA_W-1:0] logic_res;
   logic [DATA_W-1:0] shift_res;
   logic [REG_AW-1:0] dest_reg;
   logic              reg_write;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [REG_AW-1:0] out_dest;
   logic              out_reg_write;
   logic              out_zero;
   logic              out_ovf_exc;

   logic [PKT_W-1:0]  exp_q[$];
   logic [PKT_W-1:0]  mon_got;
   logic [PKT_W-1:0]  mon_exp;
   int                total;
   int                bad;

   alu_result_stage #(
      .DATA_W(DATA_W),
      .REG_AW(REG_AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .flush        (flush),
      .result_sel   (result_sel),
      .add_res      (add_res),
      .add_ovf      (add_ovf),
      .ovf_trap_en  (ovf_trap_en),
      .logic_res    (logic_res),
      .shift_res    (shift_res),
      .dest_reg     (dest_reg),
      .reg_write    (reg_write),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_dest     (out_dest),
      .out_reg_write(out_reg_write),
      .out_zero     (out_zero),
      .out_ovf_exc  (out_ovf_exc)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         mon_got = {out_result, out_dest, out_reg_write, out_zero, out_ovf_exc};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_unexpected: got packet %h, required none", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               bad++;
               $display("FAIL scoreboard_packet: got %h, required %h", mon_got, mon_exp);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] sel, input logic [31:0] a_res, input logic a_ovf,
                        input logic t_en, input logic [31:0] l_res, input logic [31:0] s_res,
                        input logic [4:0] dst, input logic rw);
      result_sel  = sel;
      add_res     = a_res;
      add_ovf     = a_ovf;
      ovf_trap_en = t_en;
      logic_res   = l_res;
      shift_res   = s_res;
      dest_reg    = dst;
      reg_write   = rw;
   endtask

   // Offers one packet, waits (bounded) for in_ready, queues the hand-computed response.
   task automatic send(input logic [1:0] sel, input logic [31:0] a_res, input logic a_ovf,
                       input logic t_en, input logic [31:0] l_res, input logic [31:0] s_res,
                       input logic [4:0] dst, input logic rw,
                       input logic [31:0] e_res, input logic e_rw, input logic e_zero,
                       input logic e_exc);
      int waited;
      drive(sel, a_res, a_ovf, t_en, l_res, s_res, dst, rw);
      in_valid = 1'b1;
      waited = 0;
      while (!in_ready && waited < 50) begin
         tick();
         waited++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready got 0 after %0d cycles, required 1", waited);
      end else begin
         exp_q.push_back({e_res, dst, e_rw, e_zero, e_exc});
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 50) begin
         tick();
         waited++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      flush       = 1'b0;
      out_ready   = 1'b0;
      drive(2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      tick();
      tick();
      check("reset_out_valid", out_valid, 0);
      check("reset_out_result", out_result, 0);
      check("reset_out_flags", {out_dest, out_reg_write, out_zero, out_ovf_exc}, 0);
      rst_n = 1'b1;
      tick();
      check("ready_after_reset", in_ready, 1);

      // 1: single shift push, one-cycle latency
      out_ready = 1'b1;
      send(2'b10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 5'd5, 1'b1,
           32'h8000_0000, 1'b1, 1'b0, 1'b0);
      check("latency_out_valid", out_valid, 1);
      check("latency_out_result", out_result, 32'h8000_0000);
      check("latency_out_dest", out_dest, 5);
      check("latency_out_zero", out_zero, 0);

      // 2: SLT with overflow correction, trap never applies to SLT
      send(2'b11, 32'h7FFF_FFFF, 1'b1, 1'b1, 32'h0, 32'h0, 5'd3, 1'b1,
           32'h0000_0001, 1'b1, 1'b0, 1'b0);
      send(2'b11, 32'h8000_0000, 1'b1, 1'b1, 32'h0, 32'h0, 5'd4, 1'b1,
           32'h0000_0000, 1'b1, 1'b1, 1'b0);
      send(2'b11, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd6, 1'b1,
           32'h0000_0001, 1'b1, 1'b0, 1'b0);

      // 3: overflow trap and its exemptions
      send(2'b00, 32'h8000_0000, 1'b1, 1'b1, 32'h0, 32'h0, 5'd7, 1'b1,
           32'h8000_0000, 1'b0, 1'b0, 1'b1);
      send(2'b00, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 32'h0, 5'd7, 1'b1,
           32'h8000_0000, 1'b1, 1'b0, 1'b0);
      send(2'b01, 32'h8000_0000, 1'b1, 1'b1, 32'h0, 32'h0, 5'd8, 1'b1,
           32'h0000_0000, 1'b1, 1'b1, 1'b0);
      send(2'b10, 32'h1, 1'b1, 1'b1, 32'h0, 32'h0000_0010, 5'd31, 1'b0,
           32'h0000_0010, 1'b0, 1'b0, 1'b0);
      send(2'b00, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1,
           32'h0000_0000, 1'b1, 1'b1, 1'b0);
      drain();

      // 4: backpressure, fill to two entries then release
      out_ready = 1'b0;
      send(2'b01, 32'h0, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h0, 5'd9, 1'b1,
           32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0);
      send(2'b00, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 32'h0, 5'd10, 1'b0,
           32'h1234_5678, 1'b0, 1'b0, 1'b0);
      check("bp_in_ready_full", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_result", out_result, 32'hA5A5_0F0F);
      tick();
      check("bp_hold_result_2", out_result, 32'hA5A5_0F0F);
      check("bp_hold_dest_2", out_dest, 9);
      out_ready = 1'b1;
      tick();
      check("bp_ready_after_pop", in_ready, 1);
      check("bp_second_head", out_result, 32'h1234_5678);
      drain();

      // 5a: flush while full, with a packet offered in the flush cycle
      out_ready = 1'b0;
      send(2'b10, 32'h0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd1, 1'b1,
           32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      send(2'b01, 32'h0, 1'b0, 1'b0, 32'h0000_0001, 32'h0, 5'd2, 1'b1,
           32'h0000_0001, 1'b1, 1'b0, 1'b0);
      check("flush_pre_full", in_ready, 0);
      exp_q.delete();
      drive(2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, 5'd31, 1'b1);
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("flush_c_dropped", out_valid, 0);

      // 5b: a pop in the flush cycle still completes
      out_ready = 1'b0;
      send(2'b01, 32'h0, 1'b0, 1'b0, 32'h0000_0F00, 32'h0, 5'd12, 1'b1,
           32'h0000_0F00, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b1;
      flush     = 1'b1;
      tick();
      flush     = 1'b0;
      check("flush_pop_out_valid", out_valid, 0);
      check("flush_pop_delivered", exp_q.size(), 0);

      // 5c: asynchronous reset mid-cycle with two entries held
      out_ready = 1'b0;
      send(2'b10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000_00FF, 5'd13, 1'b1,
           32'h0000_00FF, 1'b1, 1'b0, 1'b0);
      send(2'b00, 32'h0000_0042, 1'b1, 1'b1, 32'h0, 32'h0, 5'd14, 1'b1,
           32'h0000_0042, 1'b0, 1'b0, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_out_result", out_result, 0);
      check("async_rst_out_flags", {out_dest, out_reg_write, out_zero, out_ovf_exc}, 0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);
      out_ready = 1'b1;
      send(2'b00, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd15, 1'b1,
           32'h0000_0000, 1'b1, 1'b1, 1'b0);
      drain();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
